rv64g_l2_mshr: RTL and testbench
================================

# rv64g_l2_mshr

Single-entry miss-status holding register for the RV64G shared L2. It records one outstanding TileLink A-channel transaction: address, source ID and request type. It also tracks which L1 cores still owe a ProbeAck before the transaction may complete. The L2 controller allocates it on a miss or coherence action, programs and retires probes, and deallocates it on completion.

## Interface
Parameters:
- ADDR_W, 64: request address width.
- SOURCE_W, 6: TileLink source-ID width.
- TYPE_W, 3: request type/opcode width.
- CORES, 4: number of probe-able cores; power of two, ≥2.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- alloc_req_i  in  1  allocate request.
- alloc_addr_i  in  ADDR_W  address to record.
- alloc_source_i  in  SOURCE_W  source ID to record.
- alloc_type_i  in  TYPE_W  request type to record (e.g. 4 = Get).
- alloc_ready_o  out  1  entry free; allocation will be accepted.
- dealloc_req_i  in  1  free the entry.
- set_probes_i  in  1  load the pending-probe mask.
- probes_mask_i  in  CORES  cores to wait on (bit i = core i).
- probe_ack_i  in  1  a ProbeAck arrived.
- probe_ack_id_i  in  $clog2(CORES)  acking core index.
- valid_o  out  1  entry occupied.
- addr_o  out  ADDR_W  recorded address.
- source_o  out  SOURCE_W  recorded source.
- type_o  out  TYPE_W  recorded type.
- pending_probes_o  out  CORES  outstanding probe bitmap.

## Operation
- Two states: FREE (valid=0) and BUSY (valid=1).
- alloc_ready_o = !valid, combinational from the register.
- FREE, alloc_req_i=1: capture addr, source and type. Set valid. Clear pending to 0. Go BUSY.
- alloc_req_i while BUSY is ignored; no field changes.
- BUSY, dealloc_req_i=1: clear valid and pending. Go FREE. addr, source and type hold their last values.
- dealloc_req_i while FREE is ignored.
- BUSY, set_probes_i=1: pending ← probes_mask_i, overwriting the previous value.
- BUSY, probe_ack_i=1: clear bit probe_ack_id_i of pending; other bits unchanged.
- Acking a bit that is already 0 has no effect. An id ≥ CORES has no effect.
- set_probes_i and probe_ack_i while FREE are ignored.
- Same-cycle priority:
  - dealloc beats set_probes and probe_ack; the entry is freed and pending is 0.
  - set_probes together with probe_ack: pending ← probes_mask_i & ~(1 << probe_ack_id_i).
  - alloc with anything else while FREE: allocation wins; other inputs are ignored.
- Output fields are direct register outputs; no combinational path from inputs to outputs.
- No internal completion decision. The controller watches for pending_probes_o == 0 and issues dealloc itself.

## Timing
- Reset (rst=1 at a clock edge): valid_o=0, alloc_ready_o=1, addr_o=0, source_o=0, type_o=0, pending_probes_o=0.
- Reset overrides all requests in the same cycle and may be asserted mid-transaction.
- Request latency: every request sampled at edge N is visible on outputs after edge N. This applies to alloc, dealloc, set_probes and probe_ack.
- Allocation handshake: a request is accepted on the edge where alloc_req_i && alloc_ready_o. The requester must hold alloc_req_i only until that edge.
- A one-cycle pulse suffices for every request; level-held requests re-apply each cycle.
- Back-to-back: dealloc at edge N permits a new alloc at edge N+1 (ready is high after N).

## Structure
- Shared L2 package holds:
  - TileLink A-channel opcode constants: Get=4, PutFullData=0, PutPartialData=1, AcquireBlock=6, AcquirePerm=7.
  - Default widths: ADDR_W, SOURCE_W, TYPE_W, CORES.
- Single flat module with no sub-modules.
- The L2 instantiates an array of this module externally; the array is not part of this block.

## Test plan
- Reset, then alloc addr 0x1000, source 0x1A, type 4 for one cycle.
  - Next cycle: valid_o=1, addr_o=0x1000, source_o=0x1A, type_o=4, alloc_ready_o=0.
- While BUSY, set_probes with mask 4'b1101 → pending_probes_o=4'b1101.
  - Then probe_ack id 2 → 4'b1001.
  - Then ack id 1 → still 4'b1001.
- Dealloc pulse → valid_o=0, alloc_ready_o=1, pending_probes_o=0.
  - Then alloc addr 0x2000 on the very next cycle → accepted.
- Alloc while BUSY with addr 0x3000 → fields unchanged.
  - set_probes and probe_ack while FREE → pending stays 0.
- Same cycle set_probes mask 4'b1111 and ack id 0 → 4'b1110.
  - Same cycle dealloc, set_probes and ack → valid_o=0, pending_probes_o=0.
- Assert rst mid-transaction with pending 4'b1001 → all outputs at reset values next cycle.

Source files
------------

// File: rtl/rv64g_l2_mshr_pkg.sv
// Shared L2 definitions: TileLink A-channel opcodes, default MSHR widths and the
// MSHR state encoding.
package rv64g_l2_mshr_pkg;

  localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_A_GET              = 3'd4;
  localparam logic [2:0] TL_A_ACQUIRE_BLOCK    = 3'd6;
  localparam logic [2:0] TL_A_ACQUIRE_PERM     = 3'd7;

  localparam int L2_ADDR_W   = 64;
  localparam int L2_SOURCE_W = 6;
  localparam int L2_TYPE_W   = 3;
  localparam int L2_CORES    = 4;

  typedef enum logic {
    ST_FREE = 1'b0,
    ST_BUSY = 1'b1
  } mshr_state_e;

endpackage

// File: rtl/rv64g_l2_mshr_if.sv
// Control/status bundle between the L2 controller (master) and one MSHR entry (slave).
interface rv64g_l2_mshr_if
  import rv64g_l2_mshr_pkg::*;
#(
    parameter int ADDR_W   = L2_ADDR_W,
    parameter int SOURCE_W = L2_SOURCE_W,
    parameter int TYPE_W   = L2_TYPE_W,
    parameter int CORES    = L2_CORES
);
    localparam int ID_W = $clog2(CORES);

    logic                alloc_req_i;
    logic [ADDR_W-1:0]   alloc_addr_i;
    logic [SOURCE_W-1:0] alloc_source_i;
    logic [TYPE_W-1:0]   alloc_type_i;
    logic                alloc_ready_o;
    logic                dealloc_req_i;
    logic                set_probes_i;
    logic [CORES-1:0]    probes_mask_i;
    logic                probe_ack_i;
    logic [ID_W-1:0]     probe_ack_id_i;
    logic                valid_o;
    logic [ADDR_W-1:0]   addr_o;
    logic [SOURCE_W-1:0] source_o;
    logic [TYPE_W-1:0]   type_o;
    logic [CORES-1:0]    pending_probes_o;

    modport master (
        output alloc_req_i, alloc_addr_i, alloc_source_i, alloc_type_i,
        output dealloc_req_i, set_probes_i, probes_mask_i, probe_ack_i, probe_ack_id_i,
        input  alloc_ready_o, valid_o, addr_o, source_o, type_o, pending_probes_o
    );

    modport slave (
        input  alloc_req_i, alloc_addr_i, alloc_source_i, alloc_type_i,
        input  dealloc_req_i, set_probes_i, probes_mask_i, probe_ack_i, probe_ack_id_i,
        output alloc_ready_o, valid_o, addr_o, source_o, type_o, pending_probes_o
    );

endinterface

// File: rtl/rv64g_l2_mshr.sv
// Single-entry L2 miss-status holding register: records one outstanding A-channel
// request and the set of cores that still owe a ProbeAck.
module rv64g_l2_mshr
  import rv64g_l2_mshr_pkg::*;
#(
    parameter int ADDR_W   = L2_ADDR_W,
    parameter int SOURCE_W = L2_SOURCE_W,
    parameter int TYPE_W   = L2_TYPE_W,
    parameter int CORES    = L2_CORES
) (
    input  logic            clk,
    input  logic            rst,
    rv64g_l2_mshr_if.slave  bus
);
    localparam int ID_W = $clog2(CORES);

    mshr_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SOURCE_W-1:0] source_q, source_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic [CORES-1:0]    pending_q, pending_d;
    logic [CORES-1:0]    ack_mask;

    // One-hot of the acking core; ids outside 0..CORES-1 decode to nothing.
    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < CORES; i++) begin
            if (bus.probe_ack_i && (bus.probe_ack_id_i == ID_W'(i))) ack_mask[i] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        source_d  = source_q;
        type_d    = type_q;
        pending_d = pending_q;
        case (state_q)
            ST_FREE: begin
                if (bus.alloc_req_i) begin
                    addr_d    = bus.alloc_addr_i;
                    source_d  = bus.alloc_source_i;
                    type_d    = bus.alloc_type_i;
                    pending_d = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.dealloc_req_i) begin
                    pending_d = '0;
                    state_d   = ST_FREE;
                end else begin
                    if (bus.set_probes_i) pending_d = bus.probes_mask_i;
                    pending_d = pending_d & ~ack_mask;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FREE;
            addr_q    <= '0;
            source_q  <= '0;
            type_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            source_q  <= source_d;
            type_q    <= type_d;
            pending_q <= pending_d;
        end
    end

    assign bus.valid_o          = (state_q == ST_BUSY);
    assign bus.alloc_ready_o    = (state_q != ST_BUSY);
    assign bus.addr_o           = addr_q;
    assign bus.source_o         = source_q;
    assign bus.type_o           = type_q;
    assign bus.pending_probes_o = pending_q;

endmodule

// File: tb/tb_rv64g_l2_mshr.sv
// Directed bench for rv64g_l2_mshr: the driver queues hand-computed expected
// outputs per cycle, a monitor pops and compares them after each rising edge.
module tb_rv64g_l2_mshr;
    import rv64g_l2_mshr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv64g_l2_mshr_if #(.ADDR_W(64), .SOURCE_W(6), .TYPE_W(3), .CORES(4)) bus ();

    rv64g_l2_mshr #(.ADDR_W(64), .SOURCE_W(6), .TYPE_W(3), .CORES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [63:0] addr;
        logic [5:0]  src;
        logic [2:0]  typ;
        logic [3:0]  pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string step, input string field, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got 0x%0h want 0x%0h", step, field, act, req);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.name, "valid",   64'(bus.valid_o),          64'(e.valid));
                chk(e.name, "ready",   64'(bus.alloc_ready_o),    64'(!e.valid));
                chk(e.name, "addr",    bus.addr_o,                e.addr);
                chk(e.name, "source",  64'(bus.source_o),         64'(e.src));
                chk(e.name, "type",    64'(bus.type_o),           64'(e.typ));
                chk(e.name, "pending", 64'(bus.pending_probes_o), 64'(e.pend));
            end
        end
    end

    // Drive one cycle of inputs on the falling edge and queue the outputs expected
    // after the following rising edge.
    task automatic step(input string name, input logic r,
                        input logic a, input logic [63:0] ad, input logic [5:0] s, input logic [2:0] t,
                        input logic d, input logic sp, input logic [3:0] m,
                        input logic pa, input logic [1:0] id,
                        input logic ev, input logic [63:0] ea, input logic [5:0] es,
                        input logic [2:0] et, input logic [3:0] ep);
        exp_t e;
        @(negedge clk);
        rst                = r;
        bus.alloc_req_i    = a;
        bus.alloc_addr_i   = ad;
        bus.alloc_source_i = s;
        bus.alloc_type_i   = t;
        bus.dealloc_req_i  = d;
        bus.set_probes_i   = sp;
        bus.probes_mask_i  = m;
        bus.probe_ack_i    = pa;
        bus.probe_ack_id_i = id;
        e.name = name; e.valid = ev; e.addr = ea; e.src = es; e.typ = et; e.pend = ep;
        exp_q.push_back(e);
    endtask

    initial begin
        bus.alloc_req_i    = 1'b0;
        bus.alloc_addr_i   = '0;
        bus.alloc_source_i = '0;
        bus.alloc_type_i   = '0;
        bus.dealloc_req_i  = 1'b0;
        bus.set_probes_i   = 1'b0;
        bus.probes_mask_i  = '0;
        bus.probe_ack_i    = 1'b0;
        bus.probe_ack_id_i = '0;

        //    name          rst alloc addr        src    type                dl sp mask     ack id    | v  addr        src    type  pend
        step("reset0",      1, 0, 64'h0,      6'h00, 3'd0,               0, 0, 4'b0000, 0, 2'd0,  0, 64'h0,      6'h00, 3'd0, 4'b0000);
        step("reset1",      1, 1, 64'h5555,   6'h15, 3'd5,               1, 1, 4'b1111, 0, 2'd0,  0, 64'h0,      6'h00, 3'd0, 4'b0000);
        step("alloc1",      0, 1, 64'h1000,   6'h1A, TL_A_GET,           0, 0, 4'b0000, 0, 2'd0,  1, 64'h1000,   6'h1A, 3'd4, 4'b0000);
        step("idle",        0, 0, 64'h0,      6'h00, 3'd0,               0, 0, 4'b0000, 0, 2'd0,  1, 64'h1000,   6'h1A, 3'd4, 4'b0000);
        step("setp1101",    0, 0, 64'h0,      6'h00, 3'd0,               0, 1, 4'b1101, 0, 2'd0,  1, 64'h1000,   6'h1A, 3'd4, 4'b1101);
        step("ack2",        0, 0, 64'h0,      6'h00, 3'd0,               0, 0, 4'b0000, 1, 2'd2,  1, 64'h1000,   6'h1A, 3'd4, 4'b1001);
        step("ack1_zero",   0, 0, 64'h0,      6'h00, 3'd0,               0, 0, 4'b0000, 1, 2'd1,  1, 64'h1000,   6'h1A, 3'd4, 4'b1001);
        step("ack3",        0, 0, 64'h0,      6'h00, 3'd0,               0, 0, 4'b0000, 1, 2'd3,  1, 64'h1000,   6'h1A, 3'd4, 4'b0001);
        step("dealloc",     0, 0, 64'h0,      6'h00, 3'd0,               1, 0, 4'b0000, 0, 2'd0,  0, 64'h1000,   6'h1A, 3'd4, 4'b0000);
        step("alloc2_b2b",  0, 1, 64'h2000,   6'h05, TL_A_ACQUIRE_BLOCK, 0, 0, 4'b0000, 0, 2'd0,  1, 64'h2000,   6'h05, 3'd6, 4'b0000);
        step("alloc_busy",  0, 1, 64'h3000,   6'h3F, TL_A_PUT_FULL_DATA, 0, 0, 4'b0000, 0, 2'd0,  1, 64'h2000,   6'h05, 3'd6, 4'b0000);
        step("dealloc2",    0, 0, 64'h0,      6'h00, 3'd0,               1, 0, 4'b0000, 0, 2'd0,  0, 64'h2000,   6'h05, 3'd6, 4'b0000);
        step("dealloc_fr",  0, 0, 64'h0,      6'h00, 3'd0,               1, 0, 4'b0000, 0, 2'd0,  0, 64'h2000,   6'h05, 3'd6, 4'b0000);
        step("probe_free",  0, 0, 64'h0,      6'h00, 3'd0,               0, 1, 4'b1111, 1, 2'd0,  0, 64'h2000,   6'h05, 3'd6, 4'b0000);
        step("alloc_wins",  0, 1, 64'h4000,   6'h11, TL_A_ACQUIRE_PERM,  1, 1, 4'b1111, 1, 2'd1,  1, 64'h4000,   6'h11, 3'd7, 4'b0000);
        step("setp_ack0",   0, 0, 64'h0,      6'h00, 3'd0,               0, 1, 4'b1111, 1, 2'd0,  1, 64'h4000,   6'h11, 3'd7, 4'b1110);
        step("setp_over",   0, 0, 64'h0,      6'h00, 3'd0,               0, 1, 4'b0011, 0, 2'd0,  1, 64'h4000,   6'h11, 3'd7, 4'b0011);
        step("dl_beats",    0, 0, 64'h0,      6'h00, 3'd0,               1, 1, 4'b1111, 1, 2'd1,  0, 64'h4000,   6'h11, 3'd7, 4'b0000);
        step("alloc3",      0, 1, 64'hDEAD_0040, 6'h2B, TL_A_PUT_PARTIAL_DATA, 0, 0, 4'b0000, 0, 2'd0, 1, 64'hDEAD_0040, 6'h2B, 3'd1, 4'b0000);
        step("setp1001",    0, 0, 64'h0,      6'h00, 3'd0,               0, 1, 4'b1001, 0, 2'd0,  1, 64'hDEAD_0040, 6'h2B, 3'd1, 4'b1001);
        step("rst_mid",     1, 0, 64'h0,      6'h00, 3'd0,               0, 0, 4'b0000, 1, 2'd0,  0, 64'h0,      6'h00, 3'd0, 4'b0000);
        step("post_rst",    0, 0, 64'h0,      6'h00, 3'd0,               0, 0, 4'b0000, 0, 2'd0,  0, 64'h0,      6'h00, 3'd0, 4'b0000);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
